// File: rtl/dvbc_qam_mapper_if.sv
// dvbc_qam_mapper_if: byte-side and symbol-side handshake bundle for the
// DVB-C QAM mapper. The mapper attaches through the slave modport and the
// surrounding modulator (or a bench) drives it through the master modport.
interface dvbc_qam_mapper_if #(
  parameter int OUT_W = 8
);
  logic [1:0]              mode_i;
  logic [7:0]              s_data_i;
  logic                    s_valid_i;
  logic                    s_ready_o;
  logic signed [OUT_W-1:0] m_i_o;
  logic signed [OUT_W-1:0] m_q_o;
  logic                    m_valid_o;
  logic                    m_ready_i;

  modport slave (
    input  mode_i,
    input  s_data_i,
    input  s_valid_i,
    output s_ready_o,
    output m_i_o,
    output m_q_o,
    output m_valid_o,
    input  m_ready_i
  );

  modport master (
    output mode_i,
    output s_data_i,
    output s_valid_i,
    input  s_ready_o,
    input  m_i_o,
    input  m_q_o,
    input  m_valid_o,
    output m_ready_i
  );
endinterface

// File: rtl/dvbc_qam_mapper.sv
// dvbc_qam_mapper: DVB-C byte-to-symbol converter and 16/64/256-QAM mapper.
// Bytes enter a 16-bit MSB-first bit buffer, m-bit symbols are cut from the
// top, the two MSBs select the quadrant and the remaining bits pick the point
// inside it. Full valid/ready backpressure on both sides.
// Optional feature macro: DVBC_QAM_MAPPER_DIFF_EN enables differential coding
// of the quadrant bits; without it the quadrant bits pass straight through.
module dvbc_qam_mapper #(
  parameter int OUT_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  dvbc_qam_mapper_if.slave       bus
);

  // Bit buffer is left-aligned: the oldest valid bit sits in r_buf[15]
  logic [15:0]             r_buf;
  logic [4:0]              r_cnt;
  logic [1:0]              r_mode;
  logic signed [OUT_W-1:0] r_out_i;
  logic signed [OUT_W-1:0] r_out_q;
  logic                    r_out_valid;

  logic [4:0]  w_m;
  logic [2:0]  w_ix;
  logic [2:0]  w_iy;
  logic        w_ready;
  logic        w_accept;
  logic        w_extract;
  logic        w_transfer;
  logic [4:0]  w_cnt_left;
  logic [15:0] w_buf_left;
  logic [4:0]  w_cnt_next;
  logic [15:0] w_buf_next;
  logic        w_a;
  logic        w_b;
  logic        w_qi;
  logic        w_qq;
  logic signed [5:0] w_bx;
  logic signed [5:0] w_by;
  logic signed [5:0] w_rot_i;
  logic signed [5:0] w_rot_q;

  // Symbol width and in-quadrant index fields for the active constellation
  always_comb begin
    w_m  = 5'd4;
    w_ix = {2'b00, r_buf[13]};
    w_iy = {2'b00, r_buf[12]};
    case (r_mode)
      2'd1: begin
        w_m  = 5'd6;
        w_ix = {1'b0, r_buf[13:12]};
        w_iy = {1'b0, r_buf[11:10]};
      end
      2'd2: begin
        w_m  = 5'd8;
        w_ix = r_buf[13:11];
        w_iy = r_buf[10:8];
      end
      default: begin
        w_m  = 5'd4;
        w_ix = {2'b00, r_buf[13]};
        w_iy = {2'b00, r_buf[12]};
      end
    endcase
  end

  assign w_ready    = (r_cnt <= 5'd8);
  assign w_accept   = bus.s_valid_i & w_ready;
  assign w_transfer = r_out_valid & bus.m_ready_i;
  assign w_extract  = (r_cnt >= w_m) & (~r_out_valid | bus.m_ready_i);

  // Extraction removes the top bits first, then a new byte lands right below
  // whatever is left, so accept and extract can share one edge.
  assign w_cnt_left = w_extract ? (r_cnt - w_m) : r_cnt;
  assign w_buf_left = w_extract ? (r_buf << w_m) : r_buf;
  assign w_buf_next = w_accept ? (w_buf_left | ({bus.s_data_i, 8'h00} >> w_cnt_left))
                               : w_buf_left;
  assign w_cnt_next = w_accept ? (w_cnt_left + 5'd8) : w_cnt_left;

  assign w_a = r_buf[15];
  assign w_b = r_buf[14];

`ifdef DVBC_QAM_MAPPER_DIFF_EN
  logic r_ip;
  logic r_qp;
  logic w_x;

  assign w_x  = w_a ^ w_b;
  assign w_qi = w_x ? (w_a ^ r_qp) : (w_a ^ r_ip);
  assign w_qq = w_x ? (w_b ^ r_ip) : (w_b ^ r_qp);

  // Previous quadrant bits, advanced on every symbol cut from the buffer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ip <= 1'b0;
      r_qp <= 1'b0;
    end else if (w_extract) begin
      r_ip <= w_qi;
      r_qp <= w_qq;
    end
  end
`else
  assign w_qi = w_a;
  assign w_qq = w_b;
`endif

  // Odd-integer base point (2*ix+1, 2*iy+1) in the first quadrant
  assign w_bx = $signed({2'b00, w_ix, 1'b1});
  assign w_by = $signed({2'b00, w_iy, 1'b1});

  // Rotate the base point into the quadrant selected by the coded bits
  always_comb begin
    w_rot_i = w_bx;
    w_rot_q = w_by;
    case ({w_qi, w_qq})
      2'b00: begin
        w_rot_i = w_bx;
        w_rot_q = w_by;
      end
      2'b10: begin
        w_rot_i = -w_by;
        w_rot_q = w_bx;
      end
      2'b11: begin
        w_rot_i = -w_bx;
        w_rot_q = -w_by;
      end
      default: begin
        w_rot_i = w_by;
        w_rot_q = -w_bx;
      end
    endcase
  end

  // Bit buffer, fill count and mode; mode only moves when the buffer is idle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_buf  <= 16'h0000;
      r_cnt  <= 5'd0;
      r_mode <= 2'd0;
    end else begin
      r_buf <= w_buf_next;
      r_cnt <= w_cnt_next;
      if ((r_cnt == 5'd0) && !w_accept) begin
        r_mode <= bus.mode_i;
      end
    end
  end

  // Output symbol register, held until the downstream filter takes it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_i     <= '0;
      r_out_q     <= '0;
      r_out_valid <= 1'b0;
    end else if (w_extract) begin
      r_out_i     <= OUT_W'(w_rot_i);
      r_out_q     <= OUT_W'(w_rot_q);
      r_out_valid <= 1'b1;
    end else if (w_transfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.s_ready_o = w_ready;
  assign bus.m_i_o     = r_out_i;
  assign bus.m_q_o     = r_out_q;
  assign bus.m_valid_o = r_out_valid;

endmodule

// File: tb/tb_dvbc_qam_mapper.sv
// tb_dvbc_qam_mapper: directed bench for the DVB-C QAM mapper. A queue-based
// model of the bit stream predicts every output cycle; directed vectors with
// hand-worked constellation points pin that model down.
// Honours DVBC_QAM_MAPPER_DIFF_EN the same way the design does.
module tb_dvbc_qam_mapper;
  localparam int OUT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  dvbc_qam_mapper_if #(.OUT_W(OUT_W)) bus ();

  dvbc_qam_mapper #(.OUT_W(OUT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Reference model state: pending bits in arrival order plus output register
  bit modelBits[$];
  int modelMode  = 0;
  bit modelIp    = 1'b0;
  bit modelQp    = 1'b0;
  bit modelValid = 1'b0;
  int modelI     = 0;
  int modelQ     = 0;

  // Symbols actually handed downstream, for the directed expectations
  int logI[$];
  int logQ[$];
  logic [OUT_W-1:0] logRawI[$];
  logic [OUT_W-1:0] logRawQ[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int bitsPerSymbol(input int mode);
    return (mode == 1) ? 6 : (mode == 2) ? 8 : 4;
  endfunction

  task automatic modelReset();
    modelBits  = {};
    modelMode  = 0;
    modelIp    = 1'b0;
    modelQp    = 1'b0;
    modelValid = 1'b0;
    modelI     = 0;
    modelQ     = 0;
  endtask

  task automatic modelStep();
    int m;
    int cnt;
    int q;
    int ix;
    int iy;
    int x;
    int y;
    bit a;
    bit b;
    bit iBit;
    bit qBit;
    bit accept;
    bit extract;
    m       = bitsPerSymbol(modelMode);
    cnt     = modelBits.size();
    accept  = bus.s_valid_i && (cnt <= 8);
    extract = (cnt >= m) && (!modelValid || bus.m_ready_i);
    if ((cnt == 0) && !accept) modelMode = int'(bus.mode_i);
    if (extract) begin
      a  = modelBits.pop_front();
      b  = modelBits.pop_front();
      q  = (m - 2) / 2;
      ix = 0;
      iy = 0;
      for (int k = 0; k < q; k++) ix = ix * 2 + int'(modelBits.pop_front());
      for (int k = 0; k < q; k++) iy = iy * 2 + int'(modelBits.pop_front());
      x = 2 * ix + 1;
      y = 2 * iy + 1;
`ifdef DVBC_QAM_MAPPER_DIFF_EN
      if (a ^ b) begin
        iBit = a ^ modelQp;
        qBit = b ^ modelIp;
      end else begin
        iBit = a ^ modelIp;
        qBit = b ^ modelQp;
      end
      modelIp = iBit;
      modelQp = qBit;
`else
      iBit = a;
      qBit = b;
`endif
      if (!iBit && !qBit) begin
        modelI = x;  modelQ = y;
      end else if (iBit && !qBit) begin
        modelI = -y; modelQ = x;
      end else if (iBit && qBit) begin
        modelI = -x; modelQ = -y;
      end else begin
        modelI = y;  modelQ = -x;
      end
      modelValid = 1'b1;
    end else if (modelValid && bus.m_ready_i) begin
      modelValid = 1'b0;
    end
    if (accept) begin
      for (int k = 7; k >= 0; k--) modelBits.push_back(bus.s_data_i[k]);
    end
  endtask

  // Advance the model on every clock edge, or clear it on reset
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) modelReset();
      else modelStep();
    end
  end

  // Compare the design against the model in the middle of every cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("reset m_valid_o", int'(bus.m_valid_o), 0);
        checkOutput("reset m_i_o", int'($signed(bus.m_i_o)), 0);
        checkOutput("reset m_q_o", int'($signed(bus.m_q_o)), 0);
        checkOutput("reset s_ready_o", int'(bus.s_ready_o), 1);
      end else begin
        checkOutput("model m_valid_o", int'(bus.m_valid_o), int'(modelValid));
        checkOutput("model s_ready_o", int'(bus.s_ready_o), (modelBits.size() <= 8) ? 1 : 0);
        if (modelValid) begin
          checkOutput("model m_i_o", int'($signed(bus.m_i_o)), modelI);
          checkOutput("model m_q_o", int'($signed(bus.m_q_o)), modelQ);
        end
      end
    end
  end

  // Record every symbol that transfers on the following edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.m_valid_o && bus.m_ready_i) begin
        logI.push_back(int'($signed(bus.m_i_o)));
        logQ.push_back(int'($signed(bus.m_q_o)));
        logRawI.push_back(bus.m_i_o);
        logRawQ.push_back(bus.m_q_o);
      end
    end
  end

  // Watchdog so a stuck run still ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    logI = {};
    logQ = {};
    logRawI = {};
    logRawQ = {};
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    bit done;
    done = 1'b0;
    bus.s_data_i  = data;
    bus.s_valid_i = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      done = bus.s_ready_o;
      @(posedge clk);
      #1;
    end
    bus.s_valid_i = 1'b0;
    checkOutput("byte accepted", int'(done), 1);
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic checkSymbol(input string name, input int idx, input int ei, input int eq);
    if (logI.size() > idx) begin
      checkOutput({name, " I"}, logI[idx], ei);
      checkOutput({name, " Q"}, logQ[idx], eq);
    end else begin
      checkOutput({name, " present"}, logI.size(), idx + 1);
    end
  endtask

  logic [7:0] bpBytes [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

  initial begin
    int idx;
    bit acc;
    bus.mode_i    = 2'd0;
    bus.s_data_i  = 8'h00;
    bus.s_valid_i = 1'b0;
    bus.m_ready_i = 1'b1;
    #2 rst = 1'b1;
    tick(3);
    checkOutput("por m_valid_o", int'(bus.m_valid_o), 0);
    checkOutput("por m_i_o", int'($signed(bus.m_i_o)), 0);
    checkOutput("por m_q_o", int'($signed(bus.m_q_o)), 0);
    checkOutput("por s_ready_o", int'(bus.s_ready_o), 1);
    rst = 1'b0;
    tick(2);

    $display("[TB] 16-QAM byte 0x00");
    clearLog();
    applyStimulus(8'h00);
    tick(6);
    checkOutput("16qam 0x00 count", logI.size(), 2);
    checkSymbol("16qam 0x00 sym0", 0, 1, 1);
    checkSymbol("16qam 0x00 sym1", 1, 1, 1);

    $display("[TB] 16-QAM byte 0x8F");
    resetPulse();
    clearLog();
    applyStimulus(8'h8F);
    tick(6);
    checkOutput("16qam 0x8F count", logI.size(), 2);
    checkSymbol("16qam 0x8F sym0", 0, -1, 1);
`ifdef DVBC_QAM_MAPPER_DIFF_EN
    checkSymbol("16qam 0x8F sym1", 1, 3, -3);
`else
    checkSymbol("16qam 0x8F sym1", 1, -3, -3);
`endif

    $display("[TB] 64-QAM three zero bytes");
    bus.mode_i = 2'd1;
    resetPulse();
    clearLog();
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    tick(8);
    checkOutput("64qam count", logI.size(), 4);
    for (int k = 0; k < 4; k++) checkSymbol($sformatf("64qam sym%0d", k), k, 1, 1);
    checkOutput("64qam drained s_ready_o", int'(bus.s_ready_o), 1);

    $display("[TB] 256-QAM byte 0x3F");
    bus.mode_i = 2'd2;
    resetPulse();
    clearLog();
    applyStimulus(8'h3F);
    tick(4);
    checkOutput("256qam count", logI.size(), 1);
    checkSymbol("256qam sym0", 0, 15, 15);
    if (logRawI.size() > 0) begin
      checkOutput("256qam raw I", int'(logRawI[0]), 8'h0F);
      checkOutput("256qam raw Q", int'(logRawQ[0]), 8'h0F);
    end

    $display("[TB] backpressure");
    bus.mode_i = 2'd0;
    resetPulse();
    clearLog();
    bus.m_ready_i = 1'b0;
    idx = 0;
    bus.s_data_i  = bpBytes[0];
    bus.s_valid_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      acc = bus.s_valid_i && bus.s_ready_o;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 6) bus.s_data_i = bpBytes[idx];
        else bus.s_valid_i = 1'b0;
      end
    end
    checkOutput("bp stalled s_ready_o", int'(bus.s_ready_o), 0);
    checkOutput("bp held m_valid_o", int'(bus.m_valid_o), 1);
    checkOutput("bp held m_i_o", int'($signed(bus.m_i_o)), 1);
    checkOutput("bp held m_q_o", int'($signed(bus.m_q_o)), 3);
    checkOutput("bp bytes taken while stalled", idx, 2);
    bus.m_ready_i = 1'b1;
    for (int c = 0; c < 100 && idx < 6; c++) begin
      @(negedge clk);
      acc = bus.s_valid_i && bus.s_ready_o;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 6) bus.s_data_i = bpBytes[idx];
        else bus.s_valid_i = 1'b0;
      end
    end
    bus.s_valid_i = 1'b0;
    tick(10);
    checkOutput("bp bytes accepted", idx, 6);
    checkOutput("bp symbol count", logI.size(), 12);
    checkSymbol("bp sym0", 0, 1, 3);

    $display("[TB] mode change with half a byte buffered");
    bus.mode_i = 2'd0;
    resetPulse();
    clearLog();
    applyStimulus(8'hA5);
    tick(1);
    bus.mode_i = 2'd1;
    tick(5);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    tick(8);
    checkOutput("modechg count", logI.size(), 6);
    checkSymbol("modechg sym0", 0, -1, 3);
`ifdef DVBC_QAM_MAPPER_DIFF_EN
    checkSymbol("modechg sym1", 1, 1, 3);
`else
    checkSymbol("modechg sym1", 1, 3, -1);
`endif
    for (int k = 2; k < 6; k++) checkSymbol($sformatf("modechg sym%0d", k), k, 1, 1);

    $display("[TB] reset mid-stream");
    bus.mode_i = 2'd0;
    resetPulse();
    clearLog();
    applyStimulus(8'hFF);
    tick(1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst m_valid_o", int'(bus.m_valid_o), 0);
    checkOutput("midrst m_i_o", int'($signed(bus.m_i_o)), 0);
    checkOutput("midrst m_q_o", int'($signed(bus.m_q_o)), 0);
    checkOutput("midrst s_ready_o", int'(bus.s_ready_o), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);
    clearLog();
    applyStimulus(8'h00);
    tick(6);
    checkOutput("postrst count", logI.size(), 2);
    checkSymbol("postrst sym0", 0, 1, 1);
    checkSymbol("postrst sym1", 1, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
